// File: rtl/ram_scrambler_writer.sv
// ram_scrambler_writer: writes a new mode/seed image into the scrambler config RAM,
// verifies it by readback, and holds the scrambler in reset until the image is clean.
//   clk, reset_n          clock, asynchronous active-low reset
//   start                 load request (taken when idle or in the done cycle)
//   mode_in, seed_in      new mode bit and 256-bit seed, captured on accept
//   busy, done, error     status: update in progress, completion pulse, sticky readback mismatch
//   reset_n_scrambler     active-low reset to the scrambler
//   address, data, wren   RAM write/read port
//   q                     RAM read data, DELAY cycles after address
module ram_scrambler_writer #(
    parameter int ROM_SIZE        = 64,
    parameter int MODE_ADDR       = 0,
    parameter int SEED_ADDR_START = 32,
    parameter int DELAY           = 2,
    parameter int ADDR_W          = 7
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              mode_in,
    input  logic [255:0]      seed_in,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              reset_n_scrambler,
    output logic [ADDR_W-1:0] address,
    output logic [7:0]        data,
    output logic              wren,
    input  logic [7:0]        q
);
    typedef enum logic [1:0] {IDLE, WRITE, VERIFY, DONE} state_t;

    localparam logic [ADDR_W-1:0]        LAST_A  = ADDR_W'(ROM_SIZE - 1);
    localparam logic [ADDR_W-1:0]        MODE_A  = ADDR_W'(MODE_ADDR);
    localparam logic [ADDR_W-1:0]        SEED_A  = ADDR_W'(SEED_ADDR_START);
    localparam logic signed [ADDR_W:0]   DELAY_S = (ADDR_W + 1)'(DELAY);
    localparam logic signed [ADDR_W:0]   LAST_S  = $signed({1'b0, LAST_A});

    // Seed is stored MSB-first: seed[255:248] lands at the first seed address.
    function automatic logic [7:0] img_byte(input logic [ADDR_W-1:0] a, input logic m,
                                            input logic [255:0] s);
        return (a == MODE_A) ? {7'b0, m} :
               (a >= SEED_A) ? 8'(s >> (8 * (ROM_SIZE - 1 - int'(a)))) : 8'h00;
    endfunction

    state_t              state_q, state_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic                rsc_q, rsc_d;
    logic [ADDR_W-1:0]   address_q, address_d;
    logic [7:0]          data_q, data_d;
    logic                wren_q, wren_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                mode_q, mode_d;
    logic [255:0]        seed_q, seed_d;
    logic signed [ADDR_W:0] cmp_idx;
    logic [ADDR_W-1:0]   addr_nx;

    // One extra bit so the early verify cycles give a negative (no-compare) index.
    assign cmp_idx = $signed({1'b0, cnt_q}) - DELAY_S;
    assign addr_nx = address_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        error_d   = error_q;
        rsc_d     = rsc_q;
        address_d = address_q;
        data_d    = data_q;
        wren_d    = 1'b0;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        seed_d    = seed_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                rsc_d   = ~error_q;
                if (start) begin
                    mode_d    = mode_in;
                    seed_d    = seed_in;
                    error_d   = 1'b0;
                    busy_d    = 1'b1;
                    rsc_d     = 1'b0;
                    wren_d    = 1'b1;
                    address_d = '0;
                    data_d    = img_byte('0, mode_in, seed_in);
                    state_d   = WRITE;
                end
            end
            WRITE: begin
                wren_d    = address_q != LAST_A;
                address_d = (address_q == LAST_A) ? '0 : addr_nx;
                data_d    = img_byte(addr_nx, mode_q, seed_q);
                cnt_d     = '0;
                state_d   = (address_q == LAST_A) ? VERIFY : WRITE;
            end
            VERIFY: begin
                cnt_d     = cnt_q + 1'b1;
                address_d = (address_q == LAST_A) ? LAST_A : addr_nx;
                if (!cmp_idx[ADDR_W] && q != img_byte(cmp_idx[ADDR_W-1:0], mode_q, seed_q))
                    error_d = 1'b1;
                if (cmp_idx == LAST_S) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    address_d = '0;
                    rsc_d     = ~error_d;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            rsc_q     <= 1'b0;
            address_q <= '0;
            data_q    <= '0;
            wren_q    <= 1'b0;
            cnt_q     <= '0;
            mode_q    <= 1'b0;
            seed_q    <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
            rsc_q     <= rsc_d;
            address_q <= address_d;
            data_q    <= data_d;
            wren_q    <= wren_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            seed_q    <= seed_d;
        end
    end

    assign busy              = busy_q;
    assign done              = done_q;
    assign error             = error_q;
    assign reset_n_scrambler = rsc_q;
    assign address           = address_q;
    assign data              = data_q;
    assign wren              = wren_q;
endmodule

// File: tb/tb_ram_scrambler_writer.sv
// tb_ram_scrambler_writer: randomized bench with a RAM model and a load-phase reference model.
module tb_ram_scrambler_writer;
    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic         mode_in = 1'b0;
    logic [255:0] seed_in = '0;
    logic         busy, done, error, reset_n_scrambler, wren;
    logic [6:0]   address;
    logic [7:0]   data;
    logic [7:0]   q;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_scrambler_writer dut (
        .clk(clk), .reset_n(reset_n), .start(start), .mode_in(mode_in), .seed_in(seed_in),
        .busy(busy), .done(done), .error(error), .reset_n_scrambler(reset_n_scrambler),
        .address(address), .data(data), .wren(wren), .q(q)
    );

    // RAM model: 2-cycle read latency, optional bit-0 corruption of address 40 on readback.
    logic [7:0] mem [64];
    logic [7:0] p1;
    logic       corrupt = 1'b0;
    always @(posedge clk) begin
        if (wren) mem[address[5:0]] <= data;
        p1 <= mem[address[5:0]] ^ {7'b0, corrupt && address == 7'd40};
        q  <= p1;
    end

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", n, act, exp, $time);
        end
    endtask

    // Reference model: k counts cycles since a load was accepted (-1 when none).
    // k 0..63 write, 64..129 verify, 130 done cycle.
    int         k = -1;
    logic       exp_err = 1'b0;
    logic       exp_rsc = 1'b0;
    logic       acc;
    logic [7:0] img [64];
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            k = -1;
            exp_err = 1'b0;
            exp_rsc = 1'b0;
        end else begin
            acc = start && (k < 0 || k == 130);
            if (corrupt && k - 66 == 40) exp_err = 1'b1;
            k = (k >= 0 && k < 130) ? k + 1 : -1;
            if (k == 130) exp_rsc = !exp_err;
            if (acc) begin
                k = 0;
                exp_err = 1'b0;
                exp_rsc = 1'b0;
                for (int i = 0; i < 64; i++) img[i] = 8'h00;
                img[0] = {7'b0, mode_in};
                for (int i = 0; i < 32; i++) img[32 + i] = seed_in[255 - 8 * i -: 8];
            end else if (k < 0) begin
                exp_rsc = !exp_err;
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", 64'(busy), 64'(k >= 0 && k < 130));
        chk("done", 64'(done), 64'(k == 130));
        chk("wren", 64'(wren), 64'(k >= 0 && k < 64));
        chk("error", 64'(error), 64'(exp_err));
        chk("reset_n_scrambler", 64'(reset_n_scrambler), 64'(exp_rsc));
        if (k >= 0 && k < 64) begin
            chk("wr_addr", 64'(address), 64'(k));
            chk("wr_data", 64'(data), 64'(img[k]));
        end
        if (k >= 64 && k < 130) chk("vf_addr", 64'(address), 64'((k - 64 > 63) ? 63 : k - 64));
    end

    int wren_cnt = 0, busy_run = 0, last_busy_run = 0, low_run = 0, last_low_run = 0;
    always @(negedge clk) begin
        if (wren) wren_cnt++;
        if (busy) begin
            busy_run++;
            if (low_run != 0) last_low_run = low_run;
            low_run = 0;
        end else begin
            if (busy_run != 0) last_busy_run = busy_run;
            busy_run = 0;
            low_run++;
        end
    end

    task automatic load(input logic m, input logic [255:0] s);
        @(negedge clk);
        mode_in = m;
        seed_in = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string n);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            seen = done;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: done=0 required 1 within 400 cycles", n);
        end
    endtask

    function automatic logic [255:0] rnd_seed();
        logic [255:0] s;
        for (int j = 0; j < 8; j++) s[32 * j +: 32] = $urandom();
        return s;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] s0;
        logic         found;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_addr", 64'(address), 64'h0);
        chk("rst_data", 64'(data), 64'h0);
        chk("rst_scr", 64'(reset_n_scrambler), 64'h0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rel_scr", 64'(reset_n_scrambler), 64'h1);

        // Basic load
        wren_cnt = 0;
        load(1'b1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
        wait_done("basic");
        @(negedge clk);
        chk("basic_mem0", 64'(mem[0]), 64'h01);
        chk("basic_mem1", 64'(mem[1]), 64'h00);
        chk("basic_mem31", 64'(mem[31]), 64'h00);
        chk("basic_mem32", 64'(mem[32]), 64'h00);
        chk("basic_mem33", 64'(mem[33]), 64'h01);
        chk("basic_mem63", 64'(mem[63]), 64'h1f);
        chk("basic_wren_cycles", 64'(wren_cnt), 64'd64);
        chk("basic_busy_cycles", 64'(last_busy_run), 64'd130);
        chk("basic_error", 64'(error), 64'h0);
        chk("basic_scr", 64'(reset_n_scrambler), 64'h1);

        // Readback mismatch, then a clean reload
        corrupt = 1'b1;
        load(1'b0, rnd_seed());
        wait_done("mismatch");
        chk("mm_error", 64'(error), 64'h1);
        chk("mm_scr", 64'(reset_n_scrambler), 64'h0);
        repeat (3) @(negedge clk);
        chk("mm_scr_held", 64'(reset_n_scrambler), 64'h0);
        corrupt = 1'b0;
        load(1'b1, rnd_seed());
        wait_done("mm_clean");
        @(negedge clk);
        chk("clean_error", 64'(error), 64'h0);
        chk("clean_scr", 64'(reset_n_scrambler), 64'h1);

        // Ignored start and input changes during the write phase
        s0 = rnd_seed();
        load(1'b0, s0);
        repeat (20) @(negedge clk);
        start = 1'b1;
        seed_in = ~s0;
        mode_in = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignored");
        @(negedge clk);
        chk("ign_busy_cycles", 64'(last_busy_run), 64'd130);
        chk("ign_mem0", 64'(mem[0]), 64'h00);
        chk("ign_mem32", 64'(mem[32]), 64'(s0[255:248]));
        chk("ign_mem63", 64'(mem[63]), 64'(s0[7:0]));

        // Reset in the middle of the write phase
        load(1'b1, rnd_seed());
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            found = wren && address == 7'd20;
        end
        chk("midrst_reached_addr20", 64'(found), 64'h1);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'h0);
        chk("midrst_done", 64'(done), 64'h0);
        chk("midrst_error", 64'(error), 64'h0);
        chk("midrst_scr", 64'(reset_n_scrambler), 64'h0);
        chk("midrst_addr", 64'(address), 64'h0);
        chk("midrst_data", 64'(data), 64'h0);
        chk("midrst_wren", 64'(wren), 64'h0);
        @(negedge clk);
        wren_cnt = 0;
        reset_n = 1'b1;
        @(posedge clk);
        #1 chk("midrst_scr_release", 64'(reset_n_scrambler), 64'h1);
        repeat (10) @(negedge clk);
        chk("midrst_no_wren", 64'(wren_cnt), 64'h0);

        // Back-to-back with start held through done
        @(negedge clk);
        mode_in = 1'b0;
        seed_in = rnd_seed();
        start = 1'b1;
        wait_done("b2b_first");
        @(negedge clk);
        start = 1'b0;
        chk("b2b_restart", 64'(busy), 64'h1);
        wait_done("b2b_second");
        @(negedge clk);
        chk("b2b_gap", 64'(last_low_run), 64'd1);
        chk("b2b_busy_cycles", 64'(last_busy_run), 64'd130);

        // Byte order
        load(1'b0, {8'hAA, 248'h0});
        wait_done("byteorder");
        @(negedge clk);
        chk("bo_mem32", 64'(mem[32]), 64'haa);
        chk("bo_mem33", 64'(mem[33]), 64'h00);
        chk("bo_mem63", 64'(mem[63]), 64'h00);
        chk("bo_mem0", 64'(mem[0]), 64'h00);

        // Random loads with random gaps, stray starts and corruption
        for (int r = 0; r < 8; r++) begin
            corrupt = ($urandom_range(0, 3) == 0);
            repeat ($urandom_range(0, 4)) @(negedge clk);
            load(1'($urandom_range(0, 1)), rnd_seed());
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 120)) @(negedge clk);
                start = 1'b1;
                seed_in = ~seed_in;
                mode_in = ~mode_in;
                @(negedge clk);
                start = 1'b0;
            end
            wait_done("random");
        end
        corrupt = 1'b0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
